bp_resolve_update: RTL and testbench

- Producer/resolver end of the PC-to-branch-predictor path.
- Owns the global history register (GHR) and the pattern history table (PHT) of 2-bit saturating counters.
- Front end: supplies `pred_taken`/`pred_pht_index` for the current PC; these feed the PC/BP pipeline register's `is_branch_taken_in`/`pht_index_in`.
- Back end: accepts resolved-branch records from execute, buffers them in a small FIFO, and retires one per cycle into the PHT and GHR.

---
 rtl/bp_resolve_update_pkg.sv | 26 ++
 rtl/bp_update_fifo.sv | 57 +++++
 rtl/bp_resolve_update.sv | 84 ++++++++
 tb/tb_bp_resolve_update.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_resolve_update_pkg.sv
// Shared branch-predictor definitions: GHR sizing, PHT counter encodings and
// the 2-bit saturating counter step.
package bp_resolve_update_pkg;

    localparam int BP_GHR_WIDTH = 10;

    typedef logic [BP_GHR_WIDTH-1:0] ghr_bus_t;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } pht_cnt_e;

    localparam pht_cnt_e PHT_RESET = WEAK_NT;

    // Saturating step: never wraps past STRONG_T or below STRONG_NT.
    function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == STRONG_T) ? cnt : cnt + 2'd1;
        end
        return (cnt == STRONG_NT) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Small circular FIFO with valid/ready push, pop enable and explicit occupancy
// count (pointers alone cannot tell full from empty).
module bp_update_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_en,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_fire;
    logic             pop_fire;

    // Ready looks only at occupancy, so a full FIFO refuses a push even in a pop cycle.
    assign push_ready = (count_reg < CNT_W'(DEPTH)) && rst;
    assign empty      = (count_reg == '0);
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_en && !empty;
    assign pop_data   = mem[rd_ptr_reg];
    assign count      = count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push_fire) - CNT_W'(pop_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/bp_resolve_update.sv
// Branch predictor front-end lookup plus resolved-branch retirement into the
// gshare PHT and the global history register.
module bp_resolve_update
    import bp_resolve_update_pkg::*;
#(
    parameter int GHR_WIDTH  = BP_GHR_WIDTH,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    output logic                  pred_taken,
    output logic [GHR_WIDTH-1:0]  pred_pht_index,
    input  logic                  update_valid,
    output logic                  update_ready,
    input  logic [GHR_WIDTH-1:0]  update_pht_index,
    input  logic                  update_taken,
    input  logic                  stall_update,
    output logic [GHR_WIDTH-1:0]  ghr_out,
    output logic [CNT_W-1:0]      fifo_count
);

    localparam int PHT_ENTRIES = 2 ** GHR_WIDTH;

    logic [1:0]           pht_reg [PHT_ENTRIES];
    logic [GHR_WIDTH-1:0] ghr_reg;

    logic                 fifo_empty;
    logic                 retire;
    logic [GHR_WIDTH:0]   retire_data;
    logic [GHR_WIDTH-1:0] retire_index;
    logic                 retire_taken;
    logic [1:0]           retire_cnt_next;
    logic                 unused_pc_bits;

    bp_update_fifo #(
        .WIDTH (GHR_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (update_valid),
        .push_ready (update_ready),
        .push_data  ({update_pht_index, update_taken}),
        .pop_en     (!stall_update),
        .pop_data   (retire_data),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Lookup reads committed state only; a retire becomes visible next cycle.
    assign pred_pht_index = pred_pc[GHR_WIDTH+1:2] ^ ghr_reg;
    assign pred_taken     = pht_reg[pred_pht_index][1];
    assign unused_pc_bits = ^{pred_pc[ADDR_WIDTH-1:GHR_WIDTH+2], pred_pc[1:0]};

    assign retire          = !fifo_empty && !stall_update;
    assign retire_index    = retire_data[GHR_WIDTH:1];
    assign retire_taken    = retire_data[0];
    assign retire_cnt_next = pht_next(pht_reg[retire_index], retire_taken);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_reg[i] <= PHT_RESET;
            end
        end else if (retire) begin
            pht_reg[retire_index] <= retire_cnt_next;
        end
    end

    // Newest outcome enters at the LSB so the history follows resolution order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_reg <= '0;
        end else if (retire) begin
            ghr_reg <= {ghr_reg[GHR_WIDTH-2:0], retire_taken};
        end
    end

    assign ghr_out = ghr_reg;

endmodule

// File: tb/tb_bp_resolve_update.sv
// Self-checking bench for bp_resolve_update: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_bp_resolve_update;

    localparam int GW = 10;
    localparam int AW = 32;
    localparam int FD = 4;
    localparam int CW = 3;
    localparam int NENT = 1 << GW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] pred_pc = '0;
    logic          pred_taken;
    logic [GW-1:0] pred_pht_index;
    logic          update_valid = 1'b0;
    logic          update_ready;
    logic [GW-1:0] update_pht_index = '0;
    logic          update_taken = 1'b0;
    logic          stall_update = 1'b0;
    logic [GW-1:0] ghr_out;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    bp_resolve_update #(
        .GHR_WIDTH  (GW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .pred_pht_index   (pred_pht_index),
        .update_valid     (update_valid),
        .update_ready     (update_ready),
        .update_pht_index (update_pht_index),
        .update_taken     (update_taken),
        .stall_update     (stall_update),
        .ghr_out          (ghr_out),
        .fifo_count       (fifo_count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: counters as plain integers, pending records in a queue.
    typedef struct {
        int idx;
        bit taken;
    } rec_t;

    int   m_pht [NENT];
    int   m_ghr;
    rec_t m_q [$];

    typedef struct {
        bit       valid;
        int       idx;
        bit       taken;
        bit       stall;
        bit [31:0] pc;
        int       exp_count;
        int       exp_ghr;
        bit       exp_taken;
        int       exp_pidx;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) m_pht[i] = 1;
        m_ghr = 0;
        m_q.delete();
    endtask

    function automatic int m_pidx();
        return ((pred_pc >> 2) % NENT) ^ m_ghr;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".fifo_count"}, 32'(fifo_count), m_q.size());
        chk({tag, ".update_ready"}, 32'(update_ready), (m_q.size() < FD) ? 1 : 0);
        chk({tag, ".ghr_out"}, 32'(ghr_out), m_ghr);
        chk({tag, ".pred_pht_index"}, 32'(pred_pht_index), m_pidx());
        chk({tag, ".pred_taken"}, 32'(pred_taken), (m_pht[m_pidx()] >= 2) ? 1 : 0);
    endtask

    // One clock: decide accept/retire from pre-edge state, then advance the model.
    task automatic step(input string tag);
        bit   acc;
        bit   pop;
        rec_t r;
        acc = update_valid && (m_q.size() < FD);
        pop = (m_q.size() > 0) && !stall_update;
        @(posedge clk);
        #1;
        if (pop) begin
            r = m_q.pop_front();
            if (r.taken) m_pht[r.idx] = (m_pht[r.idx] == 3) ? 3 : m_pht[r.idx] + 1;
            else         m_pht[r.idx] = (m_pht[r.idx] == 0) ? 0 : m_pht[r.idx] - 1;
            m_ghr = ((m_ghr << 1) | int'(r.taken)) % NENT;
        end
        if (acc) begin
            r.idx   = int'(update_pht_index);
            r.taken = update_taken;
            m_q.push_back(r);
        end
        check_all(tag);
    endtask

    task automatic push_drain(input int idx, input bit taken);
        update_valid     = 1'b1;
        update_pht_index = GW'(idx);
        update_taken     = taken;
        step("push");
        update_valid = 1'b0;
        step("drain");
    endtask

    task automatic probe(input int idx, input bit exp, input string name);
        pred_pc = AW'(((idx ^ m_ghr) % NENT) << 2);
        #1;
        chk(name, 32'(pred_taken), 32'(exp));
    endtask

    vec_t vecs [4];
    int   exp_nt [4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        pred_pc = 32'h18;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.update_ready", 32'(update_ready), 0);
        chk("rst.fifo_count", 32'(fifo_count), 0);
        chk("rst.ghr_out", 32'(ghr_out), 0);
        chk("rst.pred_taken", 32'(pred_taken), 0);
        chk("rst.pred_pht_index", 32'(pred_pht_index), 32'h006);
        rst = 1'b1;
        #1;
        chk("rel.update_ready", 32'(update_ready), 1);

        vecs[0] = '{1'b1, 5, 1'b1, 1'b0, 32'h18, 1, 0, 1'b0, 6};
        vecs[1] = '{1'b1, 5, 1'b1, 1'b0, 32'h18, 1, 1, 1'b0, 7};
        vecs[2] = '{1'b0, 5, 1'b1, 1'b0, 32'h18, 0, 3, 1'b1, 5};
        vecs[3] = '{1'b0, 0, 1'b0, 1'b0, 32'h14, 0, 3, 1'b0, 6};
        for (int i = 0; i < 4; i++) begin
            update_valid     = vecs[i].valid;
            update_pht_index = GW'(vecs[i].idx);
            update_taken     = vecs[i].taken;
            stall_update     = vecs[i].stall;
            pred_pc          = vecs[i].pc;
            step("tbl");
            chk($sformatf("tbl%0d.fifo_count", i), 32'(fifo_count), vecs[i].exp_count);
            chk($sformatf("tbl%0d.ghr_out", i), 32'(ghr_out), vecs[i].exp_ghr);
            chk($sformatf("tbl%0d.pred_taken", i), 32'(pred_taken), 32'(vecs[i].exp_taken));
            chk($sformatf("tbl%0d.pred_pht_index", i), 32'(pred_pht_index), vecs[i].exp_pidx);
        end

        // Saturation on entry 7.
        for (int i = 0; i < 3; i++) push_drain(7, 1'b1);
        probe(7, 1'b1, "sat.after3_taken");
        push_drain(7, 1'b1);
        probe(7, 1'b1, "sat.after4_taken");
        exp_nt = '{1, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            push_drain(7, 1'b0);
            probe(7, exp_nt[i] != 0, $sformatf("sat.nt%0d", i));
        end
        push_drain(7, 1'b1);
        probe(7, 1'b0, "sat.floor_then_taken");

        // Stalled fill, then drain with no further traffic.
        stall_update = 1'b1;
        update_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            update_pht_index = GW'(20 + i);
            update_taken     = i[0];
            step("stall_fill");
        end
        chk("stall.fifo_count_full", 32'(fifo_count), 4);
        chk("stall.ready_low", 32'(update_ready), 0);
        update_valid = 1'b0;
        stall_update = 1'b0;
        step("stall_drain");
        chk("stall.count_after_pop1", 32'(fifo_count), 3);
        chk("stall.ready_after_pop1", 32'(update_ready), 1);
        for (int i = 2; i >= 0; i--) begin
            step("stall_drain");
            chk($sformatf("stall.count_%0d", i), 32'(fifo_count), i);
        end

        // Full FIFO, stall released while the sender keeps valid high.
        stall_update = 1'b1;
        update_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            update_pht_index = GW'(40 + i);
            update_taken     = 1'b1;
            step("full_fill");
        end
        update_pht_index = GW'(50);
        stall_update     = 1'b0;
        step("full_pop");
        chk("full.no_push_in_pop_cycle", 32'(fifo_count), 3);
        step("full_pushpop");
        chk("full.push_and_pop", 32'(fifo_count), 3);
        update_valid = 1'b0;
        repeat (3) step("full_drain");
        chk("full.drained", 32'(fifo_count), 0);

        // Reset asserted between edges while two records wait.
        stall_update = 1'b1;
        update_valid = 1'b1;
        update_taken = 1'b1;
        update_pht_index = GW'(5);
        step("rst_fill");
        update_pht_index = GW'(9);
        step("rst_fill");
        update_valid = 1'b0;
        stall_update = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("midrst.fifo_count", 32'(fifo_count), 0);
        chk("midrst.ghr_out", 32'(ghr_out), 0);
        chk("midrst.update_ready", 32'(update_ready), 0);
        probe(5, 1'b0, "midrst.pht5");
        probe(7, 1'b0, "midrst.pht7");
        probe(9, 1'b0, "midrst.pht9");
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) step("post_rst_idle");
        push_drain(5, 1'b1);
        probe(5, 1'b1, "midrst.pht5_was_weak_nt");
        push_drain(7, 1'b0);
        probe(7, 1'b0, "midrst.pht7_floor");

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            update_valid     = ($urandom_range(0, 99) < 60);
            update_pht_index = GW'($urandom_range(0, 15));
            update_taken     = 1'($urandom_range(0, 1));
            stall_update     = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 1) == 1)
                pred_pc = AW'((($urandom_range(0, 15) ^ m_ghr) % NENT) << 2);
            else
                pred_pc = $urandom;
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
